// File: rtl/regfile_mp.sv
// Multi-port integer register file: N read / M write ports, same-cycle write-to-read bypass,
// per-register pending scoreboard and a background clear sweep for soft reset / context flush.
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2,
    parameter int BYPASS     = 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [NUM_WR-1:0]              i_we,
    input  logic [NUM_WR*ADDR_WIDTH-1:0]   i_waddr,
    input  logic [NUM_WR*DATA_WIDTH-1:0]   i_wdata,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   i_raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0]   o_rdata,
    input  logic                           i_sb_set,
    input  logic [ADDR_WIDTH-1:0]          i_sb_addr,
    output logic [NUM_RD-1:0]              o_rd_pending,
    input  logic                           i_clr_req,
    output logic                           o_clr_busy
);

    localparam int NREG = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] IDX_FIRST = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] IDX_LAST  = '1;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_SWEEP
    } state_t;

    logic [DATA_WIDTH-1:0] regs_q [NREG];
    logic [DATA_WIDTH-1:0] regs_d [NREG];
    logic [NREG-1:0]       pend_q;
    logic [NREG-1:0]       pend_d;
    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [ADDR_WIDTH-1:0] idx_d;

    logic [ADDR_WIDTH-1:0] waddr [NUM_WR];
    logic [DATA_WIDTH-1:0] wdata [NUM_WR];
    logic [NUM_WR-1:0]     wr_en;

    // x0 writes are filtered here so neither the array nor the bypass ever sees them
    for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
        assign waddr[w] = i_waddr[w*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata[w] = i_wdata[w*DATA_WIDTH +: DATA_WIDTH];
        assign wr_en[w] = i_we[w] && (waddr[w] != '0);
    end

    always_comb begin
        regs_d  = regs_q;
        pend_d  = pend_q;
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                // Ascending port order: the highest-index writer lands last and wins
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_en[w]) begin
                        regs_d[waddr[w]] = wdata[w];
                        pend_d[waddr[w]] = 1'b0;
                    end
                end
                // A new producer issued in the same cycle as a write keeps the register pending
                if (i_sb_set && (i_sb_addr != '0)) begin
                    pend_d[i_sb_addr] = 1'b1;
                end
                if (i_clr_req) begin
                    state_d = ST_SWEEP;
                    idx_d   = IDX_FIRST;
                end
            end
            ST_SWEEP: begin
                regs_d[idx_q] = '0;
                pend_d[idx_q] = 1'b0;
                if (idx_q == IDX_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + IDX_FIRST;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        regs_d[0] = '0;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            pend_q  <= '0;
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pend_q  <= pend_d;
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign o_clr_busy = (state_q == ST_SWEEP);

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rd;
        logic                  hit;
        logic                  sb_hit;

        assign ra     = i_raddr[r*ADDR_WIDTH +: ADDR_WIDTH];
        assign sb_hit = i_sb_set && (i_sb_addr == ra);

        // Forwarding is off while sweeping (writes are dropped) and while reset is held
        always_comb begin
            rd  = regs_q[ra];
            hit = 1'b0;
            if ((BYPASS != 0) && (state_q == ST_IDLE) && i_rst_n) begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_en[w] && (waddr[w] == ra)) begin
                        rd  = wdata[w];
                        hit = 1'b1;
                    end
                end
            end
            if (ra == '0) begin
                rd = '0;
            end
        end

        assign o_rdata[r*DATA_WIDTH +: DATA_WIDTH] = rd;
        assign o_rd_pending[r] = pend_q[ra] & ~(hit & ~sb_hit);
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench for regfile_mp: stimulus queues expected outputs, a negedge monitor
// pops and compares them. A second instance built with BYPASS=0 shares all inputs.
module tb_regfile_mp;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;
    localparam int NWR = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NWR-1:0]     we;
    logic [NWR*AW-1:0]  waddr;
    logic [NWR*DW-1:0]  wdata;
    logic [NRD*AW-1:0]  raddr;
    logic [NRD*DW-1:0]  rdata;
    logic [NRD*DW-1:0]  nb_rdata;
    logic               sb_set;
    logic [AW-1:0]      sb_addr;
    logic [NRD-1:0]     pend;
    logic [NRD-1:0]     nb_pend;
    logic               clr_req;
    logic               busy;
    logic               nb_busy;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
        .i_raddr(raddr), .o_rdata(rdata), .i_sb_set(sb_set), .i_sb_addr(sb_addr),
        .o_rd_pending(pend), .i_clr_req(clr_req), .o_clr_busy(busy)
    );

    regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(0)) dut_nb (
        .i_clk(clk), .i_rst_n(rst_n), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
        .i_raddr(raddr), .o_rdata(nb_rdata), .i_sb_set(sb_set), .i_sb_addr(sb_addr),
        .o_rd_pending(nb_pend), .i_clr_req(clr_req), .o_clr_busy(nb_busy)
    );

    // kind: 0 rdata, 1 pending, 2 busy (both instances), 3 nb rdata, 4 nb pending
    typedef struct {
        int            kind;
        int            port;
        logic [DW-1:0] exp;
        string         name;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    logic chk_vld = 1'b0;
    logic done = 1'b0;

    function automatic void expect_v(input int kind, input int port, input logic [DW-1:0] v, input string name);
        exp_t e;
        e.kind = kind;
        e.port = port;
        e.exp  = v;
        e.name = name;
        sbq.push_back(e);
    endfunction

    function automatic void exp_rd(input int p, input logic [DW-1:0] v, input string n);
        expect_v(0, p, v, n);
    endfunction

    function automatic void exp_pd(input int p, input logic b, input string n);
        expect_v(1, p, DW'(b), n);
    endfunction

    function automatic void exp_busy(input logic b, input string n);
        expect_v(2, 0, DW'({b, b}), n);
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (chk_vld) begin
                while (sbq.size() > 0) begin
                    exp_t          e;
                    logic [DW-1:0] act;
                    e = sbq.pop_front();
                    case (e.kind)
                        0:       act = rdata[e.port*DW +: DW];
                        1:       act = DW'(pend[e.port]);
                        2:       act = DW'({nb_busy, busy});
                        3:       act = nb_rdata[e.port*DW +: DW];
                        4:       act = DW'(nb_pend[e.port]);
                        default: act = 'x;
                    endcase
                    checks++;
                    if (act !== e.exp) begin
                        errors++;
                        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                    end
                end
            end
            if (done) begin
                checks++;
                if (sbq.size() != 0) begin
                    errors++;
                    $display("FAIL leftover: got %0d unchecked expectations expected 0", sbq.size());
                end
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic idle();
        we = '0; waddr = '0; wdata = '0;
        sb_set = 1'b0; sb_addr = '0; clr_req = 1'b0;
    endtask

    task automatic wr(input int p, input int a, input logic [DW-1:0] d);
        we[p] = 1'b1;
        waddr[p*AW +: AW] = AW'(a);
        wdata[p*DW +: DW] = d;
    endtask

    task automatic rd(input int a0, input int a1);
        raddr = {AW'(a1), AW'(a0)};
    endtask

    task automatic sample();
        chk_vld = 1'b1;
        @(posedge clk);
        #1;
        chk_vld = 1'b0;
        idle();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        rd(0, 0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset state, every address on both ports
        for (int a = 0; a < 32; a++) begin
            rd(a, 31 - a);
            exp_rd(0, '0, $sformatf("t1 rdata0 x%0d", a));
            exp_rd(1, '0, $sformatf("t1 rdata1 x%0d", 31 - a));
            exp_pd(0, 1'b0, $sformatf("t1 pend0 x%0d", a));
            exp_pd(1, 1'b0, $sformatf("t1 pend1 x%0d", 31 - a));
            exp_busy(1'b0, "t1 busy");
            sample();
        end

        // write conflict and bypass
        wr(0, 5, 32'h1111); wr(1, 5, 32'h2222); rd(5, 5);
        exp_rd(0, 32'h2222, "t2 bypass port0");
        exp_rd(1, 32'h2222, "t2 bypass port1");
        expect_v(3, 0, 32'h0, "t2 nb same cycle");
        sample();
        rd(5, 0);
        exp_rd(0, 32'h2222, "t2 stored");
        exp_rd(1, 32'h0, "t2 x0");
        expect_v(3, 0, 32'h2222, "t2 nb next cycle");
        sample();

        // x0 immune to writes; BYPASS=0 visibility
        wr(0, 0, 32'hDEAD); wr(1, 0, 32'hDEAD); rd(0, 0);
        exp_rd(0, 32'h0, "t3 x0 same cycle p0");
        exp_rd(1, 32'h0, "t3 x0 same cycle p1");
        expect_v(3, 0, 32'h0, "t3 nb x0 same cycle");
        sample();
        rd(0, 0);
        exp_rd(0, 32'h0, "t3 x0 next cycle");
        sample();
        wr(0, 7, 32'hA5); rd(0, 7);
        exp_rd(1, 32'hA5, "t3 bypass x7");
        expect_v(3, 1, 32'h0, "t3 nb x7 same cycle");
        sample();
        rd(0, 7);
        exp_rd(1, 32'hA5, "t3 stored x7");
        expect_v(3, 1, 32'hA5, "t3 nb x7 next cycle");
        sample();

        // scoreboard
        sb_set = 1'b1; sb_addr = 5'd9; rd(9, 9);
        exp_pd(0, 1'b0, "t4 before set");
        sample();
        rd(9, 0);
        exp_pd(0, 1'b1, "t4 pending");
        exp_pd(1, 1'b0, "t4 x0 pending");
        expect_v(4, 0, 32'h1, "t4 nb pending");
        sample();
        wr(0, 9, 32'h42); rd(9, 9);
        exp_pd(0, 1'b0, "t4 write hit masks pending");
        exp_rd(0, 32'h42, "t4 bypass x9");
        expect_v(4, 0, 32'h1, "t4 nb pending no bypass");
        sample();
        rd(9, 9);
        exp_pd(0, 1'b0, "t4 cleared after edge");
        expect_v(4, 0, 32'h0, "t4 nb cleared after edge");
        sample();
        sb_set = 1'b1; sb_addr = 5'd9; wr(1, 9, 32'h55); rd(9, 9);
        exp_pd(0, 1'b0, "t4 set+wr stored clear");
        exp_rd(0, 32'h55, "t4 set+wr bypass");
        sample();
        rd(9, 9);
        exp_pd(0, 1'b1, "t4 set wins over write");
        sample();
        sb_set = 1'b1; sb_addr = 5'd9; wr(0, 9, 32'h66); rd(9, 9);
        exp_pd(0, 1'b1, "t4 set+wr hit keeps pending");
        exp_rd(0, 32'h66, "t4 bypass x9 again");
        sample();
        rd(9, 9);
        exp_pd(0, 1'b1, "t4 still pending");
        exp_rd(0, 32'h66, "t4 stored x9");
        sample();
        sb_set = 1'b1; sb_addr = 5'd0;
        tick();
        rd(0, 0);
        exp_pd(0, 1'b0, "t4 x0 never pending");
        sample();

        // fill, then background clear
        for (int k = 0; k < 16; k++) begin
            wr(0, 2*k + 1, DW'(2*k + 1));
            if (2*k + 2 <= 31) wr(1, 2*k + 2, DW'(2*k + 2));
            tick();
        end
        sb_set = 1'b1; sb_addr = 5'd12;
        tick();
        rd(17, 12);
        exp_rd(0, 32'd17, "t5 x17 filled");
        exp_rd(1, 32'd12, "t5 x12 filled");
        exp_pd(1, 1'b1, "t5 x12 pending");
        exp_busy(1'b0, "t5 busy before req");
        clr_req = 1'b1;
        sample();
        for (int k = 1; k <= 31; k++) begin
            exp_busy(1'b1, $sformatf("t5 busy idx%0d", k));
            if (k == 5) begin
                wr(0, 3, 32'hBEEF); rd(3, 12);
                exp_rd(0, 32'h0, "t5 sweep no bypass x3");
                exp_rd(1, 32'd12, "t5 sweep x12 not yet cleared");
                exp_pd(1, 1'b1, "t5 sweep pending stored");
            end
            if (k == 6) begin
                sb_set = 1'b1; sb_addr = 5'd2;
            end
            if (k == 20) clr_req = 1'b1;
            if (k == 31) begin
                rd(31, 30);
                exp_rd(0, 32'd31, "t5 x31 before last clear");
                exp_rd(1, 32'h0, "t5 x30 cleared");
            end
            sample();
        end
        for (int a = 0; a < 32; a++) begin
            rd(a, a);
            exp_rd(0, '0, $sformatf("t5 cleared x%0d", a));
            exp_pd(0, 1'b0, $sformatf("t5 pend cleared x%0d", a));
            if (a == 0) exp_busy(1'b0, "t5 busy after sweep");
            sample();
        end

        // reset in the middle of a sweep
        wr(0, 10, 32'hAA); wr(1, 20, 32'hBB); sb_set = 1'b1; sb_addr = 5'd15;
        tick();
        rd(10, 15);
        exp_rd(0, 32'hAA, "t6 x10 written");
        exp_pd(1, 1'b1, "t6 x15 pending");
        clr_req = 1'b1;
        sample();
        for (int k = 1; k <= 9; k++) begin
            exp_busy(1'b1, $sformatf("t6 busy idx%0d", k));
            if (k == 9) begin
                rd(10, 15);
                exp_rd(0, 32'hAA, "t6 x10 before reset");
                exp_pd(1, 1'b1, "t6 x15 pending before reset");
            end
            sample();
        end
        rst_n = 1'b0;
        rd(20, 15);
        exp_rd(0, 32'h0, "t6 x20 in reset");
        exp_rd(1, 32'h0, "t6 x15 in reset");
        exp_pd(1, 1'b0, "t6 x15 pending in reset");
        exp_busy(1'b0, "t6 busy in reset");
        sample();
        rst_n = 1'b1;
        rd(10, 20);
        exp_rd(0, 32'h0, "t6 x10 after reset");
        exp_rd(1, 32'h0, "t6 x20 after reset");
        exp_busy(1'b0, "t6 busy before new req");
        clr_req = 1'b1;
        sample();
        for (int k = 1; k <= 31; k++) begin
            exp_busy(1'b1, $sformatf("t6 new sweep busy idx%0d", k));
            sample();
        end
        exp_busy(1'b0, "t6 busy after new sweep");
        sample();

        done = 1'b1;
        repeat (3) @(posedge clk);
    end

endmodule
